// File: rtl/avm_burst_arbiter.sv
// avm_burst_arbiter
//   Two-master / one-slave Avalon-MM arbiter. Grants whole transactions
//   (a complete write burst, or a read command plus all of its returned
//   beats) with round-robin fairness. Read data is routed back to the master
//   that owns the transaction.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mN_address/writedata/byteenable/burstcount/write/read   master N request
//   mN_waitrequest           stall to master N (1 unless it owns the bus)
//   mN_readdatavalid         read beat valid, owning master only
//   mN_readdata              slave read data broadcast
//   s_*                      muxed slave request / slave response
//   timeout_err              one-cycle abort pulse
//
// Configuration
//   AVM_ARB_TIMEOUT_EN  when defined, a transaction that makes no bus
//                       progress for TIMEOUT cycles is aborted and
//                       timeout_err pulses. Otherwise timeout_err is 0.
module avm_burst_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BCW     = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_address,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  input  logic [BCW-1:0]  m0_burstcount,
  input  logic            m0_write,
  input  logic            m0_read,
  output logic            m0_waitrequest,
  output logic            m0_readdatavalid,
  output logic [DW-1:0]   m0_readdata,
  input  logic [AW-1:0]   m1_address,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  input  logic [BCW-1:0]  m1_burstcount,
  input  logic            m1_write,
  input  logic            m1_read,
  output logic            m1_waitrequest,
  output logic            m1_readdatavalid,
  output logic [DW-1:0]   m1_readdata,
  output logic [AW-1:0]   s_address,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  output logic [BCW-1:0]  s_burstcount,
  output logic            s_write,
  output logic            s_read,
  input  logic            s_waitrequest,
  input  logic            s_readdatavalid,
  input  logic [DW-1:0]   s_readdata,
  output logic            timeout_err
);

  typedef enum logic [1:0] {IDLE, WRITE, RD_CMD, RD_DATA} state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic [BCW-1:0] cnt_q, cnt_d;

  logic           req0, req1, pick, pick_wr;
  logic [BCW-1:0] pick_bc;
  logic           own_wait, wr_acc, rd_acc, rdv_fwd, timeout;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Tie goes to the master that did not own the previous transaction.
  assign pick    = (req0 && req1) ? ~last_q : req1;
  assign pick_wr = pick ? m1_write : m0_write;
  assign pick_bc = pick ? m1_burstcount : m0_burstcount;

  // Slave-side mux follows the registered grant.
  assign s_address    = grant_q ? m1_address    : m0_address;
  assign s_writedata  = grant_q ? m1_writedata  : m0_writedata;
  assign s_byteenable = grant_q ? m1_byteenable : m0_byteenable;
  assign s_burstcount = grant_q ? m1_burstcount : m0_burstcount;
  assign s_write      = (state_q == WRITE)  & (grant_q ? m1_write : m0_write);
  assign s_read       = (state_q == RD_CMD) & (grant_q ? m1_read  : m0_read);

  assign own_wait       = (state_q == WRITE || state_q == RD_CMD) ? s_waitrequest : 1'b1;
  assign m0_waitrequest = grant_q ? 1'b1 : own_wait;
  assign m1_waitrequest = grant_q ? own_wait : 1'b1;

  // Beats outside RD_DATA are spurious and never forwarded.
  assign rdv_fwd          = (state_q == RD_DATA) & s_readdatavalid;
  assign m0_readdatavalid = rdv_fwd & ~grant_q;
  assign m1_readdatavalid = rdv_fwd & grant_q;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  assign wr_acc = s_write & ~s_waitrequest;
  assign rd_acc = s_read & ~s_waitrequest;

`ifdef AVM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  logic [TW-1:0] prog_q, prog_d;
  logic          progress;

  assign progress = wr_acc | rd_acc | s_readdatavalid;
  // prog_q counts consecutive stalled cycles before the current one, so the
  // abort lands on the TIMEOUT-th cycle without progress.
  assign timeout  = (state_q != IDLE) & ~progress & (prog_q == TLIM);

  always_comb begin
    prog_d = '0;
    if (state_q != IDLE && !progress) prog_d = prog_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) prog_q <= '0;
    else     prog_q <= prog_d;
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT != 0);
  assign timeout = 1'b0;
`endif

  assign timeout_err = timeout;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = pick;
          cnt_d   = (pick_bc == '0) ? BCW'(1) : pick_bc;
          state_d = pick_wr ? WRITE : RD_CMD;
        end
      end
      WRITE: begin
        if (wr_acc) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BCW'(1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      RD_CMD: begin
        if (rd_acc) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (s_readdatavalid) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BCW'(1)) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
